// File: rtl/uart_debug_poller_pkg.sv
// rtl/uart_debug_poller_pkg.sv - shared addresses and FSM encodings for the UART debug poller
package uart_debug_poller_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] DBG_ADDR0 = 5'b01000;
    localparam logic [ADDR_W-1:0] DBG_ADDR1 = 5'b01100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD0  = 2'd1;
    localparam logic [1:0] ST_RD1  = 2'd2;
    localparam logic [1:0] ST_PUSH = 2'd3;

endpackage

// File: rtl/uart_debug_poller_if.sv
// rtl/uart_debug_poller_if.sv - Wishbone read port and snapshot stream of the debug poller
interface uart_debug_poller_if #(
    parameter int TS_W = 16
);
    import uart_debug_poller_pkg::*;

    logic [ADDR_W-1:0] wbm_adr_o;
    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [31:0]       wbm_dat_i;
    logic              wbm_ack_i;

    logic              snap_valid_o;
    logic              snap_ready_i;
    logic [31:0]       snap_w0_o;
    logic [31:0]       snap_w1_o;
    logic [TS_W-1:0]   snap_ts_o;
    logic              snap_chg_o;

    modport master (
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i,
        output snap_valid_o, snap_w0_o, snap_w1_o, snap_ts_o, snap_chg_o,
        input  snap_ready_i
    );

    modport slave (
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i,
        input  snap_valid_o, snap_w0_o, snap_w1_o, snap_ts_o, snap_chg_o,
        output snap_ready_i
    );

endinterface

// File: rtl/uart_debug_poller_snap_fifo.sv
// rtl/uart_debug_poller_snap_fifo.sv - first-word-fall-through snapshot FIFO
module uart_dbg_snap_fifo #(
    parameter int WIDTH = 81,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_debug_poller.sv
// rtl/uart_debug_poller.sv - periodic Wishbone reader of the UART debug words with timestamped snapshot FIFO
module uart_debug_poller
    import uart_debug_poller_pkg::*;
#(
    parameter int POLL_DIV   = 1024,
    parameter int ACK_TO     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TS_W       = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 enable_i,
    input  logic                 clr_i,
    uart_debug_poller_if.master  bus,
    output logic                 overflow_o,
    output logic                 timeout_o
);
    localparam int PT_W = $clog2(POLL_DIV) + 1;
    localparam int WT_W = $clog2(ACK_TO) + 1;
    localparam int EW   = 64 + TS_W + 1;

    logic [1:0]        state_q, state_d;
    logic [PT_W-1:0]   timer_q, timer_d;
    logic [WT_W-1:0]   wait_q, wait_d;
    logic [TS_W-1:0]   ts_q, ts_d, cap_ts_q, cap_ts_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       w0_q, w0_d, w1_q, w1_d;
    logic [63:0]       last_q, last_d;
    logic              first_q, first_d;
    logic              ovf_q, ovf_d, to_q, to_d;

    logic              push, pop, full, empty, chg, timeout_ev;
    logic [EW-1:0]     wdata, rdata;

    assign chg = ({w0_q, w1_q} != last_q) || first_q;
    assign wdata = {w0_q, w1_q, cap_ts_q, chg};
    assign pop = !empty && bus.snap_ready_i;

    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
        wait_d     = wait_q;
        ts_d       = ts_q + 1'b1;
        cap_ts_d   = cap_ts_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        last_d     = last_q;
        first_d    = first_q;
        push       = 1'b0;
        timeout_ev = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (timer_q == '0 && enable_i) begin
                    state_d = ST_RD0;
                    timer_d = PT_W'(POLL_DIV - 1);
                end
            end
            ST_RD0, ST_RD1: begin
                // Strobe rises one cycle after the state is entered; ack only counts while cyc is up.
                if (!cyc_q) begin
                    cyc_d  = 1'b1;
                    wait_d = '0;
                    adr_d  = (state_q == ST_RD0) ? DBG_ADDR0 : DBG_ADDR1;
                end else if (bus.wbm_ack_i) begin
                    cyc_d = 1'b0;
                    if (state_q == ST_RD0) begin
                        w0_d     = bus.wbm_dat_i;
                        cap_ts_d = ts_q;
                        state_d  = ST_RD1;
                    end else begin
                        w1_d    = bus.wbm_dat_i;
                        state_d = ST_PUSH;
                    end
                end else if (wait_q == WT_W'(ACK_TO - 1)) begin
                    cyc_d      = 1'b0;
                    timeout_ev = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                push    = 1'b1;
                last_d  = {w0_q, w1_q};
                first_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        ovf_d = (push && full && !pop) ? 1'b1 : (clr_i ? 1'b0 : ovf_q);
        to_d  = timeout_ev ? 1'b1 : (clr_i ? 1'b0 : to_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            wait_q   <= '0;
            ts_q     <= '0;
            cap_ts_q <= '0;
            cyc_q    <= 1'b0;
            adr_q    <= '0;
            w0_q     <= '0;
            w1_q     <= '0;
            last_q   <= '0;
            first_q  <= 1'b1;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            wait_q   <= wait_d;
            ts_q     <= ts_d;
            cap_ts_q <= cap_ts_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            last_q   <= last_d;
            first_q  <= first_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end

    uart_dbg_snap_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.wbm_adr_o    = adr_q;
    assign bus.wbm_cyc_o    = cyc_q;
    assign bus.wbm_stb_o    = cyc_q;
    assign bus.wbm_we_o     = 1'b0;
    assign bus.wbm_sel_o    = 4'hF;
    assign bus.snap_valid_o = !empty;
    assign bus.snap_w0_o    = rdata[EW-1 -: 32];
    assign bus.snap_w1_o    = rdata[EW-33 -: 32];
    assign bus.snap_ts_o    = rdata[TS_W:1];
    assign bus.snap_chg_o   = rdata[0];
    assign overflow_o       = ovf_q;
    assign timeout_o        = to_q;

endmodule
